// File: rtl/rrat_free_list.sv
// Retirement-side rename state: the committed arch->phys map (RRAT) and a
// circular free list of physical registers. The free-list head hands out
// registers at dispatch. Commits install new mappings and recycle the
// displaced register at the tail. A flush rewinds the speculative head to
// the committed position.
module rrat_free_list #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_PHYS      = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alloc_req,
  output logic                              alloc_valid,
  output logic [PHYS_REG_BITS-1:0]          alloc_pd,
  input  logic                              commit_valid,
  input  logic [4:0]                        commit_rd,
  input  logic [PHYS_REG_BITS-1:0]          commit_pd,
  input  logic                              flush,
  output logic [PHYS_REG_BITS-1:0]          rrat [32],
  output logic [$clog2(NUM_PHYS-32):0]      free_count
);

  localparam int FL_DEPTH = NUM_PHYS - 32;
  localparam int PTR_W    = $clog2(FL_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  logic [PHYS_REG_BITS-1:0] fl [FL_DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W-1:0]         retire_head;
  logic [CNT_W-1:0]         spec_cnt;
  // Committed free count. Every commit frees one register and retires one
  // allocation, so this holds at FL_DEPTH and only serves the flush restore.
  logic [CNT_W-1:0]         ret_cnt;

  logic                     commit_en;
  logic                     alloc_fire;
  logic [PTR_W-1:0]         retire_head_nxt;

  // Outputs come straight from current state. Same-cycle commits are not bypassed.
  assign alloc_valid = (spec_cnt != '0);
  assign alloc_pd    = fl[head];
  assign free_count  = spec_cnt;

  // Qualify commit and alloc events, and form the post-commit retire head used by flush.
  always_comb begin
    commit_en       = commit_valid && (commit_rd != 5'd0);
    alloc_fire      = alloc_req && alloc_valid && !flush;
    retire_head_nxt = commit_en ? retire_head + 1'b1 : retire_head;
  end

  // Committed map and free-list storage: install the new mapping and recycle the old register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rrat[i] <= PHYS_REG_BITS'(i);
      end
      for (int j = 0; j < FL_DEPTH; j++) begin
        fl[j] <= PHYS_REG_BITS'(32 + j);
      end
    end else if (commit_en) begin
      rrat[commit_rd] <= commit_pd;
      fl[tail]        <= rrat[commit_rd];
    end
  end

  // Pointers and counts. On flush the head rewinds to the post-commit retire
  // head and any alloc in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      retire_head <= '0;
      spec_cnt    <= CNT_W'(FL_DEPTH);
      ret_cnt     <= CNT_W'(FL_DEPTH);
    end else begin
      if (commit_en) begin
        tail <= tail + 1'b1;
      end
      retire_head <= retire_head_nxt;
      if (flush) begin
        head     <= retire_head_nxt;
        spec_cnt <= ret_cnt;
      end else begin
        if (alloc_fire) begin
          head <= head + 1'b1;
        end
        spec_cnt <= spec_cnt - CNT_W'(alloc_fire) + CNT_W'(commit_en);
      end
    end
  end

  // A commit into a full free list with no offsetting alloc would overflow it.
  assert property (@(posedge clk) disable iff (rst)
    !(commit_en && (spec_cnt == CNT_W'(FL_DEPTH)) && !alloc_fire));

endmodule

// File: tb/tb_rrat_free_list.sv
// Directed bench for rrat_free_list with hand-computed expectations.
module tb_rrat_free_list;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_req = 1'b0;
  logic       alloc_valid;
  logic [5:0] alloc_pd;
  logic       commit_valid = 1'b0;
  logic [4:0] commit_rd = '0;
  logic [5:0] commit_pd = '0;
  logic       flush = 1'b0;
  logic [5:0] rrat [32];
  logic [5:0] free_count;

  int checks   = 0;
  int failures = 0;

  rrat_free_list #(.PHYS_REG_BITS(6), .NUM_PHYS(64)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_pd(alloc_pd), .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_pd(commit_pd), .flush(flush), .rrat(rrat), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; alloc_req = 1'b0; commit_valid = 1'b0;
    commit_rd = '0; commit_pd = '0; flush = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  task automatic allocs(input int n);
    for (int k = 0; k < n; k++) begin
      alloc_req = 1'b1;
      tick();
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", alloc_valid, 1);
    chk("rst_pd", alloc_pd, 32);
    chk("rst_count", free_count, 32);
    chk("rst_rrat0", rrat[0], 0);
    chk("rst_rrat5", rrat[5], 5);
    chk("rst_rrat31", rrat[31], 31);

    // Three back-to-back allocs
    for (int k = 0; k < 3; k++) begin
      chk("alloc_seq_pd", alloc_pd, 32 + k);
      alloc_req = 1'b1;
      tick();
    end
    chk("alloc3_count", free_count, 29);
    chk("alloc3_pd", alloc_pd, 35);

    // Commit recycles old mapping, then drain to empty
    do_reset();
    allocs(2);
    commit_valid = 1'b1; commit_rd = 5'd5; commit_pd = 6'd32;
    tick();
    chk("commit_rrat5", rrat[5], 32);
    chk("commit_count", free_count, 31);
    chk("commit_pd_head", alloc_pd, 34);
    for (int k = 0; k < 30; k++) begin
      chk("drain_pd", alloc_pd, 34 + k);
      alloc_req = 1'b1;
      tick();
    end
    chk("drain_wrap_pd", alloc_pd, 5);
    chk("drain_wrap_count", free_count, 1);
    allocs(1);
    chk("drain_empty_valid", alloc_valid, 0);
    chk("drain_empty_count", free_count, 0);

    // Commit to x0 is a no-op; alloc on empty list is ignored
    commit_valid = 1'b1; commit_rd = 5'd0; commit_pd = 6'd40;
    tick();
    chk("x0_rrat0", rrat[0], 0);
    chk("x0_count", free_count, 0);
    alloc_req = 1'b1;
    tick();
    chk("empty_alloc_count", free_count, 0);
    chk("empty_alloc_valid", alloc_valid, 0);
    commit_valid = 1'b1; commit_rd = 5'd6; commit_pd = 6'd40;
    tick();
    chk("x0_ptr_pd", alloc_pd, 6);
    chk("x0_ptr_count", free_count, 1);
    chk("x0_rrat6", rrat[6], 40);

    // Empty list with same-cycle ignored alloc and commit
    do_reset();
    allocs(32);
    chk("empty32_valid", alloc_valid, 0);
    chk("empty32_count", free_count, 0);
    alloc_req = 1'b1; commit_valid = 1'b1; commit_rd = 5'd1; commit_pd = 6'd32;
    tick();
    chk("refill_valid", alloc_valid, 1);
    chk("refill_pd", alloc_pd, 1);
    chk("refill_count", free_count, 1);
    chk("refill_rrat1", rrat[1], 32);

    // Alloc 4, commit, then flush
    do_reset();
    allocs(4);
    commit_valid = 1'b1; commit_rd = 5'd2; commit_pd = 6'd32;
    tick();
    chk("pre_flush_count", free_count, 29);
    flush = 1'b1;
    tick();
    chk("flush_pd", alloc_pd, 33);
    chk("flush_count", free_count, 32);
    chk("flush_rrat2", rrat[2], 32);

    // Commit, flush and alloc in the same cycle
    do_reset();
    allocs(3);
    chk("cf_pre_rrat3", rrat[3], 3);
    alloc_req = 1'b1; commit_valid = 1'b1; commit_rd = 5'd3; commit_pd = 6'd32; flush = 1'b1;
    tick();
    chk("cf_pd", alloc_pd, 33);
    chk("cf_count", free_count, 32);
    chk("cf_rrat3", rrat[3], 32);

    // Alloc and commit in the same cycle, then flush
    do_reset();
    allocs(2);
    alloc_req = 1'b1; commit_valid = 1'b1; commit_rd = 5'd7; commit_pd = 6'd33;
    tick();
    chk("ac_count", free_count, 30);
    chk("ac_pd", alloc_pd, 35);
    chk("ac_rrat7", rrat[7], 33);
    flush = 1'b1;
    tick();
    chk("ac_flush_pd", alloc_pd, 33);
    chk("ac_flush_count", free_count, 32);

    // Reset mid-stream wins over everything
    allocs(3);
    commit_valid = 1'b1; commit_rd = 5'd4; commit_pd = 6'd32;
    tick();
    chk("mid_rrat4", rrat[4], 32);
    rst = 1'b1; alloc_req = 1'b1; commit_valid = 1'b1; commit_rd = 5'd9;
    commit_pd = 6'd50; flush = 1'b1;
    tick();
    chk("mid_rst_pd", alloc_pd, 32);
    chk("mid_rst_count", free_count, 32);
    chk("mid_rst_valid", alloc_valid, 1);
    chk("mid_rst_rrat4", rrat[4], 4);
    chk("mid_rst_rrat7", rrat[7], 7);
    chk("mid_rst_rrat9", rrat[9], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
